bus_xfer_ctrl: RTL
==================

// Module: bus_xfer_ctrl
// PURPOSE
//   Sequences register-to-register moves over the shared 16-bit data bus.
//   - Reads the data_out of every bus register through an internal mux.
//   - Issues a one-hot load_enable to the destination register.
//   - Queues incoming transfer requests in a small FIFO.
//   - Runs on posedge clk, so load_en is stable before the registers capture on negedge.
// PARAMETERS
//   NREG    8   number of bus registers; also the width of load_en
//   SELW    3   width of the src/dst index; must satisfy 2**SELW >= NREG
//   DATA_W  16  bus and register data width
//   QDEPTH  4   request FIFO depth; power of two, >= 2
// PORTS
//   clk        in   1            clock; all state updates on posedge
//   reset      in   1            reset, synchronous, active-high
//   req_valid  in   1            transfer request present
//   req_ready  out  1            FIFO can accept; high when not full
//   req_src    in   SELW         source register index
//   req_dst    in   SELW         destination register index
//   reg_q      in   NREG*DATA_W  flattened register outputs; reg i at [i*DATA_W +: DATA_W]
//   bus_out    out  DATA_W       bus value driven to all register data_in ports
//   load_en    out  NREG         one-hot load enable, at most one bit high
//   busy       out  1            FSM not in IDLE, or FIFO not empty
//   done       out  1            1-cycle pulse per completed transfer
//   err        out  1            1-cycle pulse per rejected request
// BEHAVIOUR
//   - Request acceptance: a request is accepted on a posedge where req_valid && req_ready.
//     {src,dst} is pushed into the FIFO.
//   - Full FIFO: req_ready=0, including on the cycle the FIFO pops. No bypass.
//   - Pointers: FIFO pointers wrap modulo QDEPTH. A full/empty flag uses an extra pointer bit.
//   - FSM states: IDLE, SEL, LOAD, DONE.
//     - IDLE: if the FIFO is not empty, pop the head.
//       If src >= NREG or dst >= NREG, pulse err next cycle and stay in IDLE with no load.
//       Otherwise latch sel<=src and dsel<=dst, then go to SEL.
//     - SEL: bus_out = reg_q[sel]. The bus settles for one full cycle. Then go to LOAD.
//     - LOAD: load_en[dsel]=1 for exactly this cycle and bus_out is held.
//       The destination captures on this cycle's negedge. Then go to DONE.
//     - DONE: done=1 for one cycle. If the FIFO is not empty, pop and go directly to SEL.
//       Otherwise go to IDLE.
//   - Latency: with IDLE and an empty FIFO, a request accepted at edge N gives SEL at N+2,
//     LOAD at N+3 and done at N+4. Back-to-back transfers take 3 cycles each.
//   - bus_out is a combinational mux of registered sel. It drives the selected source in
//     every state, including IDLE.
//   - src==dst is legal: the register reloads its own value and done still pulses.
//   - Reset, including mid-transfer:
//     state=IDLE, FIFO flushed, sel=0, dsel=0, load_en=0, done=0, err=0, busy=0, req_ready=1.
//     A LOAD that is interrupted by reset does not assert load_en on the following cycle.
//   - reset has priority over a simultaneous req_valid. The request is not accepted.
// CONFIGURATION
//   XFER_CNT_EN defined:
//     - Adds output xfer_cnt[15:0], reset to 0.
//     - Increments on every done pulse and wraps 0xFFFF -> 0x0000.
//     - err pulses do not count.
//   XFER_CNT_EN undefined:
//     - The port and counter are absent. All other behaviour is identical.
// TESTING
//   1. Reset only: after reset, load_en=0, done=0, busy=0, req_ready=1, and bus_out=reg_q[0].
//   2. Single move: reg2=0xBEEF, request src=2 dst=5 at edge N.
//      Expect load_en=8'b0010_0000 only in cycle N+3, bus_out=0xBEEF in N+2..N+3,
//      done at N+4, and reg5=0xBEEF.
//   3. Back-to-back: push 4 requests in consecutive cycles.
//      Expect req_ready=0 only while the FIFO is full, 4 done pulses spaced 3 cycles apart,
//      and in-order completion.
//   4. Bad index: NREG=6, request src=7 dst=1.
//      Expect err=1 for one cycle, load_en never high, and no done pulse.
//   5. Reset mid-op: assert reset during SEL of a move into reg4.
//      Expect load_en[4] never asserted, the FIFO emptied, and busy=0 on the next cycle.
//   6. XFER_CNT_EN: preload xfer_cnt=0xFFFF via 65535 moves, or force it in the bench,
//      then do one move. Expect xfer_cnt=0x0000.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_ctrl
//  Description : Sequences register-to-register moves over a shared data bus.
//                Requests {src,dst} are queued in a small FIFO. For each one the
//                source is muxed onto the bus for a full cycle, then a one-hot
//                load enable strobes the destination for one cycle.
//                Optional macro XFER_CNT_EN adds a 16-bit wrapping xfer_cnt
//                output that counts completed transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl #(
    parameter int NREG   = 8,
    parameter int SELW   = 3,
    parameter int DATA_W = 16,
    parameter int QDEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SELW-1:0]        req_src,
    input  logic [SELW-1:0]        req_dst,
    input  logic [NREG*DATA_W-1:0] reg_q,
    output logic [DATA_W-1:0]      bus_out,
    output logic [NREG-1:0]        load_en,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef XFER_CNT_EN
    ,
    output logic [15:0]            xfer_cnt
`endif
);

    localparam int c_PTRW  = $clog2(QDEPTH);
    localparam int c_NSLOT = 1 << SELW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SELW-1:0]   r_sel;
    logic [SELW-1:0]   r_dsel;
    logic [SELW-1:0]   w_sel_nxt;
    logic [SELW-1:0]   w_dsel_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic [2*SELW-1:0] r_fifo [QDEPTH];
    logic [c_PTRW:0]   r_wr_ptr;
    logic [c_PTRW:0]   r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [SELW-1:0]   w_head_src;
    logic [SELW-1:0]   w_head_dst;
    logic              w_head_bad;

    logic [DATA_W-1:0] w_slot [c_NSLOT];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_PTRW] != r_rd_ptr[c_PTRW]) &&
                        (r_wr_ptr[c_PTRW-1:0] == r_rd_ptr[c_PTRW-1:0]);
    assign req_ready  = !w_full;
    assign w_push     = req_valid && !w_full;
    assign {w_head_src, w_head_dst} = r_fifo[r_rd_ptr[c_PTRW-1:0]];
    assign w_head_bad = (int'(w_head_src) >= NREG) || (int'(w_head_dst) >= NREG);

    // Unpack the flat register bus; unused index codes read as zero.
    for (genvar i = 0; i < c_NSLOT; i++) begin : g_slot
        if (i < NREG) begin : g_real
            assign w_slot[i] = reg_q[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign w_slot[i] = '0;
        end
    end

    assign bus_out = w_slot[r_sel];
    assign done    = (r_state == S_DONE);
    assign err     = r_err;
    assign busy    = (r_state != S_IDLE) || !w_empty;

    // FIFO pointer update; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage write; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[c_PTRW-1:0]] <= {req_src, req_dst};
    end

    // FSM state, selected indices and the registered error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_dsel  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_dsel  <= w_dsel_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic: IDLE and DONE both pop the head; bad indices are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_dsel_nxt  = r_dsel;
        w_pop       = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_sel_nxt   = w_head_src;
                        w_dsel_nxt  = w_head_dst;
                        w_state_nxt = S_SEL;
                    end
                end
            end
            S_SEL:   w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One-hot load strobe, decoded from registered state so reset kills it at once.
    always_comb begin
        load_en = '0;
        for (int i = 0; i < NREG; i++) begin
            if ((r_state == S_LOAD) && (int'(r_dsel) == i)) load_en[i] = 1'b1;
        end
    end

`ifdef XFER_CNT_EN
    logic [15:0] r_xfer_cnt;

    // Completed-transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)                r_xfer_cnt <= '0;
        else if (r_state == S_DONE) r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
`default_nettype wire
